// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C command master.
//   OP_*  : command opcodes on cmd_op
//   ST_*  : FSM state encoding
//   PH_*  : quarter-bit phase indices
package i2c_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

endpackage

// File: rtl/i2c_cmd_master_phase_tick.sv
// i2c_phase_tick: quarter-bit timebase for the I2C master.
//   clk, res_n : system clock, async active-low reset
//   restart    : reload divider and return to phase 0 (command accept)
//   run        : timebase advances only while an op is on the bus
//   stall      : holds the divider at terminal count (clock stretching)
//   tick       : one-cycle pulse on the last clk of each phase
//   phase      : current quarter-bit phase 0..3
module i2c_phase_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       restart,
    input  logic       run,
    input  logic       stall,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Stall only at terminal count, so the synchroniser delay overlaps the
    // normal phase length and an unstretched phase is still CLK_DIV clk.
    assign tick = run && !restart && (cnt == '0) && !stall;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt   <= LOAD;
            phase <= PH_0;
        end else if (restart) begin
            cnt   <= LOAD;
            phase <= PH_0;
        end else if (run) begin
            if (tick) begin
                cnt   <= LOAD;
                phase <= phase + 2'd1;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: command-stream driven I2C master (START/WRITE/READ/STOP).
//   clk, res_n            : system clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op, cmd_data, cmd_nack
//   rsp_valid             : one-cycle pulse at the end of every command
//   rsp_data, rsp_err     : last READ byte; slave NACK or illegal sequence
//   busy                  : bus owned between START and STOP
//   scl_oe, sda_oe        : open-drain pulls (1 = drive low)
//   scl_in, sda_in        : pad levels, synchronised internally
// Build option: I2C_CLK_STRETCH_EN enables slave clock stretching in p1.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_START | 4-phase (repeated) START condition
// ST_BIT   | 9 bits of WRITE or READ, 4 phases each
// ST_STOP  | 4-phase STOP condition
// ST_RESP  | rsp_valid pulse, then back to idle
module i2c_cmd_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_nack,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              scl_in,
    input  logic              sda_in
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    logic [2:0]        state;
    logic [1:0]        phase;
    logic              tick;
    logic              run;
    logic              stall;
    logic              accept;
    logic              rd_q;
    logic              nack_q;
    logic              last_bit;
    logic              bit_drive;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sh;
    logic [1:0]        scl_sync;
    logic [1:0]        sda_sync;
    logic              sda_s;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign run       = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);
    assign sda_s     = sda_sync[1];
    assign last_bit  = (bit_cnt == LAST_BIT);

    // Idle-high reset value so a released bus is not seen as held low.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    assign stall = run && (phase == PH_1) && !scl_sync[1];
`else
    logic scl_unused;
    assign scl_unused = scl_sync[1];
    assign stall      = 1'b0;
`endif

    i2c_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .res_n   (res_n),
        .restart (accept),
        .run     (run),
        .stall   (stall),
        .tick    (tick),
        .phase   (phase)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= ST_IDLE;
            rd_q     <= 1'b0;
            nack_q   <= 1'b0;
            bit_cnt  <= '0;
            sh       <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rd_q    <= (cmd_op == OP_READ);
                        nack_q  <= cmd_nack;
                        sh      <= (cmd_op == OP_WRITE) ? cmd_data : '0;
                        bit_cnt <= '0;
                        rsp_err <= 1'b0;
                        if (cmd_op == OP_START) begin
                            state <= ST_START;
                        end else if (!busy) begin
                            // Data or STOP without owning the bus: report, touch nothing.
                            state   <= ST_RESP;
                            rsp_err <= 1'b1;
                        end else if (cmd_op == OP_STOP) begin
                            state <= ST_STOP;
                        end else begin
                            state <= ST_BIT;
                        end
                    end
                end
                ST_START: begin
                    if (tick && phase == PH_3) begin
                        busy  <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_BIT: begin
                    if (tick && phase == PH_2) begin
                        if (last_bit) begin
                            if (!rd_q) rsp_err <= sda_s;
                        end else if (rd_q) begin
                            sh <= {sh[DATA_W-2:0], sda_s};
                        end
                    end
                    // Write data shifts after SCL is low again so SDA never
                    // moves while SCL is high.
                    if (tick && phase == PH_3) begin
                        if (last_bit) begin
                            if (rd_q) rsp_data <= sh;
                            state <= ST_RESP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!rd_q) sh <= {sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_STOP: begin
                    if (tick && phase == PH_3) begin
                        busy  <= 1'b0;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bit 9 is ACK: write releases SDA, read ACKs unless told to NACK.
    assign bit_drive = last_bit ? (rd_q && !nack_q) : (!rd_q && !sh[DATA_W-1]);

    // Between ops the owner keeps SCL low and SDA released.
    always_comb begin
        scl_oe = busy;
        sda_oe = 1'b0;
        case (state)
            ST_START: begin
                case (phase)
                    PH_0:    begin scl_oe = busy; sda_oe = 1'b0; end
                    PH_1:    begin scl_oe = 1'b0; sda_oe = 1'b0; end
                    PH_2:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b1; sda_oe = 1'b1; end
                endcase
            end
            ST_BIT: begin
                scl_oe = (phase == PH_0) || (phase == PH_3);
                sda_oe = bit_drive;
            end
            ST_STOP: begin
                case (phase)
                    PH_0:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
                    PH_1:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b0; sda_oe = 1'b0; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_cmd_master.sv
module tb_i2c_cmd_master;

    localparam int CLK_DIV   = 4;
    localparam int STRETCH_H = 21;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;
    localparam int SS = 4 * CLK_DIV;
    localparam int BB = 36 * CLK_DIV;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_line;
    logic       sda_line;

    always #5 clk = ~clk;

    i2c_cmd_master #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_line),
        .sda_in    (sda_line)
    );

    // ---------------- slave BFM ----------------
    logic       bfm_ack = 1'b1;
    logic [7:0] bfm_tx = 8'h00;
    logic       stretch_req = 1'b0;
    logic       p_scl, p_sda;
    int         bfm_bit;
    logic       first, rd_mode, ack_low, rd_active;
    logic [2:0] rd_idx;
    logic [7:0] rx, last_rx;
    logic       mst_ack_oe;
    logic       s_arm;
    int         s_cnt;
    int         oe_toggles;
    int         cyc = 0;
    logic       bfm_sda_low, bfm_scl_low;

    assign bfm_sda_low = (rd_active && !bfm_tx[3'd7 - rd_idx]) || ack_low;
    assign bfm_scl_low = s_arm && (s_cnt < STRETCH_H);
    assign sda_line = !(sda_oe || bfm_sda_low);
    assign scl_line = !(scl_oe || bfm_scl_low);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            p_scl <= 1'b0; p_sda <= 1'b0; bfm_bit <= 0; first <= 1'b0;
            rd_mode <= 1'b0; ack_low <= 1'b0; rd_active <= 1'b0; rd_idx <= 3'd0;
            rx <= 8'h00; last_rx <= 8'h00; mst_ack_oe <= 1'b0;
            s_arm <= 1'b0; s_cnt <= 0; oe_toggles <= 0;
        end else begin
            p_scl <= scl_oe;
            p_sda <= sda_oe;
            if (scl_oe != p_scl || sda_oe != p_sda) oe_toggles <= oe_toggles + 1;
            if (stretch_req && scl_oe && !p_scl && bfm_bit == 2 && !s_arm) begin
                s_arm <= 1'b1;
                s_cnt <= 0;
            end else if (s_arm) begin
                if (s_cnt == STRETCH_H) s_arm <= 1'b0;
                else if (s_cnt != 0 || !scl_oe) s_cnt <= s_cnt + 1;
            end
            if (sda_oe && !p_sda && !scl_oe && !p_scl) begin
                bfm_bit <= 0; first <= 1'b1; rd_mode <= 1'b0;
                ack_low <= 1'b0; rd_active <= 1'b0;
            end else if (!sda_oe && p_sda && !scl_oe && !p_scl) begin
                bfm_bit <= 0; first <= 1'b0; ack_low <= 1'b0; rd_active <= 1'b0;
            end else if (!scl_oe && p_scl) begin
                if (bfm_bit < 8) rx <= {rx[6:0], sda_line};
                else if (!first && rd_mode) mst_ack_oe <= sda_oe;
                bfm_bit <= bfm_bit + 1;
            end else if (scl_oe && !p_scl) begin
                if (bfm_bit == 8) begin
                    last_rx   <= rx;
                    rd_active <= 1'b0;
                    ack_low   <= (first || !rd_mode) ? bfm_ack : 1'b0;
                    if (first) rd_mode <= rx[0];
                end else if (bfm_bit == 9) begin
                    bfm_bit   <= 0;
                    first     <= 1'b0;
                    ack_low   <= 1'b0;
                    rd_active <= rd_mode;
                    rd_idx    <= 3'd0;
                end else if (bfm_bit >= 1 && bfm_bit <= 7) begin
                    rd_idx <= 3'(bfm_bit);
                end
            end
        end
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       nack;
        logic       ack;
        logic [7:0] tx;
        logic       err;
        logic       bsy;
        logic [7:0] dat;
        int         span;
        logic       chk_ack;
        logic       ack_oe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d, input logic nk,
                                input logic ack, input logic [7:0] tx, input logic err,
                                input logic bsy, input logic [7:0] dat, input int span,
                                input logic chk_ack, input logic ack_oe);
        vec_t v;
        v.op = op; v.data = d; v.nack = nk; v.ack = ack; v.tx = tx; v.err = err;
        v.bsy = bsy; v.dat = dat; v.span = span; v.chk_ack = chk_ack; v.ack_oe = ack_oe;
        return v;
    endfunction

    // Issue one command; span = clk cycles from p0 start to the RESP cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic nk,
                          output int span, output logic err_s, output logic [7:0] data_s,
                          output logic busy_s, output logic ready_s);
        int acc;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_nack = nk;
        @(negedge clk);
        acc = cyc;
        cmd_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 2000) begin @(negedge clk); guard++; end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        span   = cyc - acc;
        err_s  = rsp_err;
        data_s = rsp_data;
        busy_s = busy;
        @(negedge clk);
        ready_s = cmd_ready;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         span;
        logic       e, b, r;
        logic [7:0] dd;
        int         tog0;
        int         guard;

        #12;
        check("rst_scl_oe", 32'(scl_oe), 0);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        res_n = 1'b1;

        //                op       data   nk    ack   tx     err   bsy   data   span chk  ack_oe
        vecs.push_back(mk(C_START, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h7C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, BB, 1'b0, 1'b0));
        vecs.push_back(mk(C_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_START, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h7D, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, BB, 1'b0, 1'b0));
        vecs.push_back(mk(C_READ,  8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, BB, 1'b1, 1'b0));
        vecs.push_back(mk(C_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, BB, 1'b0, 1'b0));
        vecs.push_back(mk(C_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 0,  1'b0, 1'b0));
        vecs.push_back(mk(C_READ,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 0,  1'b0, 1'b0));
        vecs.push_back(mk(C_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 0,  1'b0, 1'b0));
        vecs.push_back(mk(C_START, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h7C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, BB, 1'b0, 1'b0));
        vecs.push_back(mk(C_START, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, SS, 1'b0, 1'b0));
        vecs.push_back(mk(C_WRITE, 8'h7D, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, BB, 1'b0, 1'b0));
        vecs.push_back(mk(C_READ,  8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, BB, 1'b1, 1'b1));
        vecs.push_back(mk(C_READ,  8'h00, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 8'h96, BB, 1'b1, 1'b0));
        vecs.push_back(mk(C_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96, SS, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            bfm_ack = vecs[i].ack;
            bfm_tx  = vecs[i].tx;
            tog0    = oe_toggles;
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].nack, span, e, dd, b, r);
            check($sformatf("v%0d_span", i), 32'(span), 32'(vecs[i].span));
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
            check($sformatf("v%0d_data", i), 32'(dd), 32'(vecs[i].dat));
            check($sformatf("v%0d_busy", i), 32'(b), 32'(vecs[i].bsy));
            check($sformatf("v%0d_ready_after", i), 32'(r), 1);
            if (vecs[i].span == 0)
                check($sformatf("v%0d_no_bus_toggle", i), 32'(oe_toggles - tog0), 0);
            if (vecs[i].op == C_WRITE && vecs[i].span != 0)
                check($sformatf("v%0d_bfm_byte", i), 32'(last_rx), 32'(vecs[i].data));
            if (vecs[i].chk_ack)
                check($sformatf("v%0d_ack_oe", i), 32'(mst_ack_oe), 32'(vecs[i].ack_oe));
        end

        // Slave stretches SCL in bit 3; the extra 20 clk only count when
        // stretching is honoured.
        bfm_ack = 1'b1;
        do_cmd(C_START, 8'h00, 1'b0, span, e, dd, b, r);
        stretch_req = 1'b1;
        do_cmd(C_WRITE, 8'h7C, 1'b0, span, e, dd, b, r);
        stretch_req = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        check("stretch_span", 32'(span), 32'(BB + 20));
`else
        check("stretch_span", 32'(span), 32'(BB));
`endif
        check("stretch_byte", 32'(last_rx), 32'h7C);
        check("stretch_err", 32'(e), 0);
        do_cmd(C_STOP, 8'h00, 1'b0, span, e, dd, b, r);
        check("stretch_stop_busy", 32'(b), 0);

        // Reset in the middle of a WRITE.
        do_cmd(C_START, 8'h00, 1'b0, span, e, dd, b, r);
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        cmd_valid = 1'b1; cmd_op = C_WRITE; cmd_data = 8'hC3; cmd_nack = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        check("mid_ready", 32'(cmd_ready), 0);
        res_n = 1'b0;
        #1;
        check("mid_rst_scl_oe", 32'(scl_oe), 0);
        check("mid_rst_sda_oe", 32'(sda_oe), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 0);
        check("post_rst_rsp_data", 32'(rsp_data), 0);
        check("post_rst_scl_oe", 32'(scl_oe), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
